// File: rtl/uart_rx_frame_counter_if.sv
// Bundle between the RX control FSM (master) and the frame counter (slave):
// run-time frame configuration going in, counters and strobes coming out.
interface uart_rx_frame_counter_if #(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 4
);
    logic               enable;
    logic [PRESC_W-1:0] prescale;
    logic [BIT_W-1:0]   data_bits;
    logic               par_en;
    logic               stop2;

    logic [PRESC_W-1:0] edge_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               sample_stb;
    logic               bit_done;
    logic               frame_done;
    logic               cfg_err;

    modport master (
        output enable, prescale, data_bits, par_en, stop2,
        input  edge_cnt, bit_cnt, sample_stb, bit_done, frame_done, cfg_err
    );

    modport slave (
        input  enable, prescale, data_bits, par_en, stop2,
        output edge_cnt, bit_cnt, sample_stb, bit_done, frame_done, cfg_err
    );
endinterface

// File: rtl/uart_rx_frame_counter.sv
// Oversampling edge/bit counter for the UART receiver. Counts clock edges
// inside each bit and bits inside each frame, for a frame shape chosen at
// run time, and decodes the three vote strobes plus bit-end / frame-end.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | not counting; live config drives the decodes and is captured
//   ST_RUN  | frame in progress; shadow config drives the decodes
module uart_rx_frame_counter #(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_rx_frame_counter_if.slave bus
);

    // One extra bit on every compare so P-1, M+1 and L-1 never wrap.
    localparam int PW = PRESC_W + 1;
    localparam int BW = BIT_W + 1;

    localparam logic [PRESC_W-1:0] P_MIN   = PRESC_W'(4);
    localparam logic [PRESC_W-1:0] P_RESET = PRESC_W'(8);
    localparam logic [BIT_W-1:0]   D_MIN   = BIT_W'(5);
    localparam logic [BIT_W-1:0]   D_MAX   = BIT_W'(9);
    localparam logic [BIT_W-1:0]   D_RESET = BIT_W'(8);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PRESC_W-1:0] edge_q;
    logic [BIT_W-1:0]   bit_q;
    logic               cfg_err_q;

    logic [PRESC_W-1:0] sh_p;
    logic [BIT_W-1:0]   sh_d;
    logic               sh_par;
    logic               sh_stop2;

    logic [PRESC_W-1:0] live_p;
    logic [BIT_W-1:0]   live_d;
    logic               live_err;

    logic [PRESC_W-1:0] act_p;
    logic [BIT_W-1:0]   act_d;
    logic               act_par;
    logic               act_stop2;

    logic [PW-1:0]      p_x;
    logic [PW-1:0]      p_last;
    logic [PW-1:0]      mid;
    logic [PW-1:0]      mid_lo;
    logic [PW-1:0]      mid_hi;
    logic [PW-1:0]      edge_x;
    logic [BW-1:0]      len_x;
    logic [BW-1:0]      len_last;
    logic [BW-1:0]      bit_x;

    logic               at_bit_end;
    logic               at_frame_end;
    logic               in_vote;
    logic               capture;

    // Clamp the live inputs into the legal range and flag anything clamped.
    always_comb begin
        live_p   = bus.prescale;
        live_d   = bus.data_bits;
        live_err = 1'b0;
        if (bus.prescale < P_MIN) begin
            live_p   = P_MIN;
            live_err = 1'b1;
        end
        if (bus.data_bits < D_MIN) begin
            live_d   = D_MIN;
            live_err = 1'b1;
        end else if (bus.data_bits > D_MAX) begin
            live_d   = D_MAX;
            live_err = 1'b1;
        end
    end

    // Live config steers the very first cycle so counting needs no skip cycle.
    always_comb begin
        act_p     = sh_p;
        act_d     = sh_d;
        act_par   = sh_par;
        act_stop2 = sh_stop2;
        if (state == ST_IDLE) begin
            act_p     = live_p;
            act_d     = live_d;
            act_par   = bus.par_en;
            act_stop2 = bus.stop2;
        end
    end

    // Widened bit-period and frame-length arithmetic plus terminal compares.
    always_comb begin
        p_x      = {1'b0, act_p};
        p_last   = p_x - PW'(1);
        mid      = p_x >> 1;
        mid_lo   = mid - PW'(1);
        mid_hi   = mid + PW'(1);
        edge_x   = {1'b0, edge_q};

        len_x    = BW'(1) + BW'(act_d) + BW'(act_par) + BW'(1) + BW'(act_stop2);
        len_last = len_x - BW'(1);
        bit_x    = {1'b0, bit_q};

        at_bit_end   = (edge_x == p_last);
        at_frame_end = at_bit_end && (bit_x == len_last);
        in_vote      = (edge_x >= mid_lo) && (edge_x <= mid_hi);

        // Recapture on frame end so back-to-back frames pick up new settings.
        capture      = bus.enable && ((state == ST_IDLE) || at_frame_end);
    end

    // Run/idle state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Enter RUN on the first enable cycle, drop back as soon as enable falls.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.enable)  state_nxt = ST_RUN;
            ST_RUN:  if (!bus.enable) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Edge and bit counters; the bit counter wraps at the last stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (!bus.enable) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (at_bit_end) begin
            edge_q <= '0;
            if (at_frame_end) begin
                bit_q <= '0;
            end else begin
                bit_q <= bit_q + BIT_W'(1);
            end
        end else begin
            edge_q <= edge_q + PRESC_W'(1);
        end
    end

    // Shadow config and its illegality flag, loaded together on capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_p      <= P_RESET;
            sh_d      <= D_RESET;
            sh_par    <= 1'b0;
            sh_stop2  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else if (capture) begin
            sh_p      <= live_p;
            sh_d      <= live_d;
            sh_par    <= bus.par_en;
            sh_stop2  <= bus.stop2;
            cfg_err_q <= live_err;
        end
    end

    assign bus.edge_cnt   = edge_q;
    assign bus.bit_cnt    = bit_q;
    assign bus.sample_stb = bus.enable && in_vote;
    assign bus.bit_done   = bus.enable && at_bit_end;
    assign bus.frame_done = bus.enable && at_frame_end;
    assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// Self-checking bench for uart_rx_frame_counter. Expected per-cycle outputs
// come from closed-form formulas of the cycle index within a frame and are
// queued when the stimulus for that cycle is driven.
module tb_uart_rx_frame_counter;

    localparam int PW = 6;
    localparam int BW = 4;

    typedef logic [PW+BW+2:0] obs_t;

    logic clk = 1'b0;
    logic rst;

    uart_rx_frame_counter_if #(.PRESC_W(PW), .BIT_W(BW)) bus ();

    uart_rx_frame_counter #(.PRESC_W(PW), .BIT_W(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];
    obs_t observed;

    assign observed = {bus.edge_cnt, bus.bit_cnt, bus.sample_stb, bus.bit_done, bus.frame_done};

    // Expected outputs at cycle c of a run with bit period p and frame length l.
    function automatic obs_t expect_at(int c, int p, int l);
        int   e;
        int   b;
        int   m;
        logic s;
        logic bd;
        logic fd;
        e  = c % p;
        b  = (c / p) % l;
        m  = p / 2;
        s  = (e >= m - 1) && (e <= m + 1);
        bd = (e == p - 1);
        fd = bd && (b == l - 1);
        return {PW'(e), BW'(b), s, bd, fd};
    endfunction

    task automatic set_cfg(int p, int d, bit par, bit s2);
        bus.prescale  = PW'(p);
        bus.data_bits = BW'(d);
        bus.par_en    = par;
        bus.stop2     = s2;
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.enable = 1'b1;
        set_cfg(8, 8, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (observed !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", observed);
        end
        checks++;
        if (bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_cfg_err got=%b want=0", bus.cfg_err);
        end
        bus.enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (observed !== '0) begin
            errors++;
            $display("FAIL idle_outputs got=%h want=0", observed);
        end
    endtask

    task automatic test_basic();
        obs_t want;
        set_cfg(8, 8, 0, 0);
        for (int c = 0; c <= 80; c++) begin
            @(negedge clk);
            bus.enable = 1'b1;
            sb.push_back(expect_at(c, 8, 10));
            #1;
            want = sb.pop_front();
            checks++;
            if (observed !== want) begin
                errors++;
                $display("FAIL basic c=%0d got=%h want=%h", c, observed, want);
            end
        end
        checks++;
        if (bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_cfg_err got=%b want=0", bus.cfg_err);
        end
        go_idle();
    endtask

    task automatic test_odd_cfg();
        obs_t want;
        set_cfg(5, 7, 1, 1);
        for (int c = 0; c <= 55; c++) begin
            @(negedge clk);
            bus.enable = 1'b1;
            sb.push_back(expect_at(c, 5, 11));
            #1;
            want = sb.pop_front();
            checks++;
            if (observed !== want) begin
                errors++;
                $display("FAIL odd_cfg c=%0d got=%h want=%h", c, observed, want);
            end
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        obs_t want;
        set_cfg(8, 8, 0, 0);
        for (int c = 0; c < 80 + 48; c++) begin
            @(negedge clk);
            bus.enable = 1'b1;
            if (c == 20) bus.prescale = PW'(16);
            if (c < 80) sb.push_back(expect_at(c, 8, 10));
            else        sb.push_back(expect_at(c - 80, 16, 10));
            #1;
            want = sb.pop_front();
            checks++;
            if (observed !== want) begin
                errors++;
                $display("FAIL back_to_back c=%0d got=%h want=%h", c, observed, want);
            end
        end
        go_idle();
    endtask

    task automatic test_illegal();
        obs_t want;
        set_cfg(2, 12, 0, 0);
        for (int c = 0; c <= 44; c++) begin
            @(negedge clk);
            bus.enable = 1'b1;
            sb.push_back(expect_at(c, 4, 11));
            #1;
            want = sb.pop_front();
            checks++;
            if (observed !== want) begin
                errors++;
                $display("FAIL illegal c=%0d got=%h want=%h", c, observed, want);
            end
            if (c == 0) begin
                checks++;
                if (bus.cfg_err !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_err_before got=%b want=0", bus.cfg_err);
                end
            end
            if (c == 1) begin
                checks++;
                if (bus.cfg_err !== 1'b1) begin
                    errors++;
                    $display("FAIL illegal_err_after got=%b want=1", bus.cfg_err);
                end
            end
        end
        go_idle();
        #1;
        checks++;
        if (bus.cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_err_hold got=%b want=1", bus.cfg_err);
        end
    endtask

    task automatic test_rst_async();
        obs_t want;
        set_cfg(2, 12, 0, 0);
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            bus.enable = 1'b1;
            sb.push_back(expect_at(c, 4, 11));
            #1;
            want = sb.pop_front();
            checks++;
            if (observed !== want) begin
                errors++;
                $display("FAIL rst_pre c=%0d got=%h want=%h", c, observed, want);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (observed !== '0) begin
            errors++;
            $display("FAIL rst_async_outputs got=%h want=0", observed);
        end
        checks++;
        if (bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_cfg_err got=%b want=0", bus.cfg_err);
        end
        @(negedge clk);
        bus.enable = 1'b0;
        rst        = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (observed !== '0) begin
                errors++;
                $display("FAIL rst_quiet k=%0d got=%h want=0", k, observed);
            end
        end
        set_cfg(8, 8, 0, 0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            bus.enable = 1'b1;
            sb.push_back(expect_at(c, 8, 10));
            #1;
            want = sb.pop_front();
            checks++;
            if (observed !== want) begin
                errors++;
                $display("FAIL rst_restart c=%0d got=%h want=%h", c, observed, want);
            end
        end
        go_idle();
    endtask

    task automatic test_abort();
        obs_t want;
        set_cfg(8, 8, 0, 0);
        for (int c = 0; c < 38; c++) begin
            @(negedge clk);
            bus.enable = 1'b1;
            sb.push_back(expect_at(c, 8, 10));
            #1;
            want = sb.pop_front();
            checks++;
            if (observed !== want) begin
                errors++;
                $display("FAIL abort_run c=%0d got=%h want=%h", c, observed, want);
            end
            if (c == 1) begin
                checks++;
                if (bus.cfg_err !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_err_clear got=%b want=0", bus.cfg_err);
                end
            end
        end
        @(negedge clk);
        bus.enable = 1'b0;
        sb.push_back({PW'(6), BW'(4), 1'b0, 1'b0, 1'b0});
        #1;
        want = sb.pop_front();
        checks++;
        if (observed !== want) begin
            errors++;
            $display("FAIL abort_drop got=%h want=%h", observed, want);
        end
        @(negedge clk);
        sb.push_back('0);
        #1;
        want = sb.pop_front();
        checks++;
        if (observed !== want) begin
            errors++;
            $display("FAIL abort_cleared got=%h want=%h", observed, want);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.enable = 1'b1;
            sb.push_back(expect_at(c, 8, 10));
            #1;
            want = sb.pop_front();
            checks++;
            if (observed !== want) begin
                errors++;
                $display("FAIL abort_restart c=%0d got=%h want=%h", c, observed, want);
            end
        end
        go_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_odd_cfg();
        test_back_to_back();
        test_illegal();
        test_rst_async();
        test_abort();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
